// File: rtl/lin_map_pkg.sv
// lin_map_pkg: basis-change matrices around the DOM AES S-box
// plus a GF(2) matrix-vector helper shared by RTL and bench.
package lin_map_pkg;

   // Index [r] holds row r, i.e. the mask that produces output bit r.
   typedef logic [7:0][7:0] mat_t;

   typedef enum logic {
      MAP_SBOX_OUT = 1'b0,
      MAP_SBOX_IN  = 1'b1
   } map_sel_e;

   localparam mat_t M_OUT = {
      8'h28, 8'h88, 8'h41, 8'hA8,
      8'hF8, 8'h6D, 8'h32, 8'h52
   };

   localparam mat_t M_IN = {
      8'hE7, 8'h71, 8'h63, 8'hE1,
      8'h9B, 8'h01, 8'h61, 8'h4F
   };

   localparam mat_t MINV_OUT = {
      8'h90, 8'h53, 8'h50, 8'h4B,
      8'hD0, 8'hA4, 8'h19, 8'h73
   };

   localparam mat_t MINV_IN = {
      8'h12, 8'hEB, 8'hED, 8'h42,
      8'h7E, 8'hB2, 8'h22, 8'h04
   };

   function automatic logic [7:0] gf2_mat_apply(
      input mat_t       m,
      input logic [7:0] x
   );
      logic [7:0] y;
      for (int r = 0; r < 8; r++) begin
         y[r] = ^(m[r] & x);
      end
      return y;
   endfunction

   function automatic mat_t minv_of(input int sel);
      return (sel == int'(MAP_SBOX_IN)) ? MINV_IN : MINV_OUT;
   endfunction

endpackage

// File: rtl/lin_map_inv_share.sv
// lin_map_inv_share: combinational inverse basis change of one share.
// One instance per share so shares never meet before a register.
module lin_map_inv_share
   import lin_map_pkg::*;
#(
   parameter int MATRIX_SEL = 0
) (
   input  logic [7:0] x_i,
   output logic [7:0] y_o
);

   localparam mat_t MINV = minv_of(MATRIX_SEL);

   assign y_o = gf2_mat_apply(MINV, x_i);

endmodule

// File: rtl/lin_map_inv_pipe.sv
// lin_map_inv_pipe: masked, pipelined inverse basis change with
// optional remasking and a valid/ready stage chain.
module lin_map_inv_pipe
   import lin_map_pkg::*;
#(
   parameter int MATRIX_SEL  = 0,
   parameter int N_SHARES    = 2,
   parameter int PIPE_STAGES = 2,
   parameter int REMASK      = 1
) (
   input  logic                      ClkxCI,
   input  logic                      RstxRI,
   input  logic                      InValidxSI,
   output logic                      InReadyxSO,
   input  logic [8*N_SHARES-1:0]     DataInxDI,
   input  logic [8*(N_SHARES-1)-1:0] RandxDI,
   output logic                      OutValidxSO,
   input  logic                      OutReadyxSI,
   output logic [8*N_SHARES-1:0]     DataOutxDO
);

   localparam int DW = 8 * N_SHARES;
   localparam int RW = 8 * (N_SHARES - 1);

   logic [DW-1:0] lin;
   logic [RW-1:0] rnd_in;
   logic          v1_q;
   logic          v1_d;
   logic          ld1;
   logic          adv1;
   logic [DW-1:0] d1_q;
   logic [RW-1:0] r1_q;
   logic [DW-1:0] rm;
   logic [7:0]    rsum;

   for (genvar i = 0; i < N_SHARES; i++) begin : g_share
      lin_map_inv_share #(
         .MATRIX_SEL(MATRIX_SEL)
      ) u_share (
         .x_i(DataInxDI[8*i +: 8]),
         .y_o(lin[8*i +: 8])
      );
   end

   if (REMASK != 0) begin : g_rnd
      assign rnd_in = RandxDI;
   end else begin : g_nornd
      logic unused_rand;
      assign unused_rand = ^RandxDI;
      assign rnd_in      = '0;
   end

   assign InReadyxSO = ~v1_q | adv1;
   assign ld1        = InValidxSI & InReadyxSO;
   assign v1_d       = ld1 | (v1_q & ~adv1);

   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         v1_q <= 1'b0;
         d1_q <= '0;
         r1_q <= '0;
      end else begin
         v1_q <= v1_d;
         if (ld1) begin
            d1_q <= lin;
            r1_q <= rnd_in;
         end
      end
   end

   // Last share absorbs the XOR of all fresh masks, taken from registers.
   always_comb begin
      rsum = '0;
      rm   = d1_q;
      for (int i = 0; i < N_SHARES - 1; i++) begin
         rsum          = rsum ^ r1_q[8*i +: 8];
         rm[8*i +: 8]  = d1_q[8*i +: 8] ^ r1_q[8*i +: 8];
      end
      rm[8*(N_SHARES-1) +: 8] = d1_q[8*(N_SHARES-1) +: 8] ^ rsum;
   end

   if (PIPE_STAGES == 2) begin : g_p2
      logic          v2_q;
      logic          v2_d;
      logic          ld2;
      logic [DW-1:0] d2_q;

      assign ld2  = v1_q & (~v2_q | OutReadyxSI);
      assign adv1 = ld2;
      assign v2_d = ld2 | (v2_q & ~OutReadyxSI);

      always_ff @(posedge ClkxCI) begin
         if (RstxRI) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v2_d;
            if (ld2) begin
               d2_q <= rm;
            end
         end
      end

      assign OutValidxSO = v2_q;
      assign DataOutxDO  = d2_q;
   end else begin : g_p1
      assign adv1        = v1_q & OutReadyxSI;
      assign OutValidxSO = v1_q;
      assign DataOutxDO  = rm;
   end

endmodule

// File: tb/tb_lin_map_inv_pipe.sv
// tb_lin_map_inv_pipe: scoreboard bench over four parameter sets
// (sel0/N2/raw/P2, sel1/N2/raw/P2, sel0/N3/remask/P2, sel1/N3/remask/P1).
module tb_lin_map_inv_pipe;
   import lin_map_pkg::*;

   typedef struct {
      logic [31:0] sh;
      logic [7:0]  plain;
      bit          xonly;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  iv;
   logic [3:0]  ordy;
   wire  [3:0]  ir;
   wire  [3:0]  ov;
   logic [31:0] din  [4];
   logic [31:0] rnd  [4];
   wire  [31:0] dout [4];
   exp_t        nexp [4];
   exp_t        q    [4][$];
   bit          hold_pend [4];
   logic [31:0] hold_val  [4];
   bit          acc [4];
   int          checks = 0;
   int          errors = 0;

   logic [15:0] a_do, b_do;
   logic [23:0] c_do, d_do;

   always #5 clk = ~clk;

   lin_map_inv_pipe #(
      .MATRIX_SEL(0), .N_SHARES(2), .PIPE_STAGES(2), .REMASK(0)
   ) u_a (
      .ClkxCI(clk), .RstxRI(rst),
      .InValidxSI(iv[0]), .InReadyxSO(ir[0]),
      .DataInxDI(din[0][15:0]), .RandxDI(rnd[0][7:0]),
      .OutValidxSO(ov[0]), .OutReadyxSI(ordy[0]),
      .DataOutxDO(a_do)
   );

   lin_map_inv_pipe #(
      .MATRIX_SEL(1), .N_SHARES(2), .PIPE_STAGES(2), .REMASK(0)
   ) u_b (
      .ClkxCI(clk), .RstxRI(rst),
      .InValidxSI(iv[1]), .InReadyxSO(ir[1]),
      .DataInxDI(din[1][15:0]), .RandxDI(rnd[1][7:0]),
      .OutValidxSO(ov[1]), .OutReadyxSI(ordy[1]),
      .DataOutxDO(b_do)
   );

   lin_map_inv_pipe #(
      .MATRIX_SEL(0), .N_SHARES(3), .PIPE_STAGES(2), .REMASK(1)
   ) u_c (
      .ClkxCI(clk), .RstxRI(rst),
      .InValidxSI(iv[2]), .InReadyxSO(ir[2]),
      .DataInxDI(din[2][23:0]), .RandxDI(rnd[2][15:0]),
      .OutValidxSO(ov[2]), .OutReadyxSI(ordy[2]),
      .DataOutxDO(c_do)
   );

   lin_map_inv_pipe #(
      .MATRIX_SEL(1), .N_SHARES(3), .PIPE_STAGES(1), .REMASK(1)
   ) u_d (
      .ClkxCI(clk), .RstxRI(rst),
      .InValidxSI(iv[3]), .InReadyxSO(ir[3]),
      .DataInxDI(din[3][23:0]), .RandxDI(rnd[3][15:0]),
      .OutValidxSO(ov[3]), .OutReadyxSI(ordy[3]),
      .DataOutxDO(d_do)
   );

   assign dout[0] = {16'h0, a_do};
   assign dout[1] = {16'h0, b_do};
   assign dout[2] = {8'h0, c_do};
   assign dout[3] = {8'h0, d_do};

   function automatic int pipe(input int i);
      return (i == 3) ? 1 : 2;
   endfunction

   function automatic int nsh(input int i);
      return (i < 2) ? 2 : 3;
   endfunction

   function automatic mat_t minv(input int i);
      return (i == 0 || i == 2) ? MINV_OUT : MINV_IN;
   endfunction

   function automatic mat_t fwd(input int i);
      return (i == 0 || i == 2) ? M_OUT : M_IN;
   endfunction

   function automatic logic [7:0] bm(input mat_t m, input logic [7:0] x);
      logic [7:0] y = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            y[r] = y[r] ^ (m[r][c] & x[c]);
      return y;
   endfunction

   function automatic logic [31:0] model(
      input int i, input logic [31:0] d, input logic [31:0] r
   );
      logic [31:0] y  = '0;
      logic [7:0]  rs = '0;
      int          n  = nsh(i);
      for (int s = 0; s < n; s++) y[8*s +: 8] = bm(minv(i), d[8*s +: 8]);
      if (i >= 2) begin
         for (int s = 0; s < n - 1; s++) begin
            y[8*s +: 8] = y[8*s +: 8] ^ r[8*s +: 8];
            rs          = rs ^ r[8*s +: 8];
         end
         y[8*(n-1) +: 8] = y[8*(n-1) +: 8] ^ rs;
      end
      return y;
   endfunction

   task automatic idle_all();
      iv = '0;
      for (int i = 0; i < 4; i++) begin
         din[i] = '0;
         rnd[i] = '0;
      end
   endtask

   task automatic cycle();
      exp_t       e;
      logic       want;
      logic [7:0] x;
      #1;
      for (int i = 0; i < 4; i++) begin
         want = (q[i].size() < pipe(i)) || ordy[i];
         checks++;
         if (ir[i] !== want) begin
            errors++;
            $display("FAIL ready dut%0d got %b want %b occ %0d",
                     i, ir[i], want, q[i].size());
         end
         if (hold_pend[i]) begin
            checks++;
            if (ov[i] !== 1'b1 || dout[i] !== hold_val[i]) begin
               errors++;
               $display("FAIL hold dut%0d got v%b %h want v1 %h",
                        i, ov[i], dout[i], hold_val[i]);
            end
         end
         if (ov[i] && ordy[i]) begin
            checks++;
            if (q[i].size() == 0) begin
               errors++;
               $display("FAIL spurious dut%0d got %h want none", i, dout[i]);
            end else begin
               e = q[i].pop_front();
               if (e.xonly) begin
                  x = '0;
                  for (int s = 0; s < nsh(i); s++) x = x ^ dout[i][8*s +: 8];
                  if (x !== e.plain) begin
                     errors++;
                     $display("FAIL unmask dut%0d got %h want %h",
                              i, x, e.plain);
                  end
               end else if (dout[i] !== e.sh) begin
                  errors++;
                  $display("FAIL data dut%0d got %h want %h",
                           i, dout[i], e.sh);
               end
            end
         end
         hold_pend[i] = ov[i] && !ordy[i];
         hold_val[i]  = dout[i];
         acc[i]       = iv[i] && ir[i];
         if (acc[i]) q[i].push_back(nexp[i]);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int k = 0;
      idle_all();
      ordy = '1;
      while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0
             && k < 20) begin
         cycle();
         k++;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q[i].size() != 0) begin
            errors++;
            $display("FAIL drain dut%0d got %0d left want 0", i, q[i].size());
         end
      end
   endtask

   task automatic check_idle(input int i, input string tag);
      checks++;
      if (ov[i] !== 1'b0 || dout[i] !== 32'h0 || ir[i] !== 1'b1) begin
         errors++;
         $display("FAIL %s dut%0d got v%b d%h r%b want v0 d0 r1",
                  tag, i, ov[i], dout[i], ir[i]);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      ordy = '0;
      idle_all();
      for (int i = 0; i < 4; i++) begin
         hold_pend[i] = 1'b0;
         acc[i]       = 1'b0;
         nexp[i]      = '{32'h0, 8'h0, 1'b0};
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) check_idle(i, "reset");
   endtask

   task automatic test_matrix();
      logic [7:0] u;
      for (int k = 0; k < 8; k++) begin
         u = 8'h01 << k;
         checks++;
         if (bm(M_OUT, bm(MINV_OUT, u)) !== u ||
             bm(MINV_OUT, bm(M_OUT, u)) !== u) begin
            errors++;
            $display("FAIL inv_out col%0d got %h want %h",
                     k, bm(M_OUT, bm(MINV_OUT, u)), u);
         end
         checks++;
         if (bm(M_IN, bm(MINV_IN, u)) !== u ||
             bm(MINV_IN, bm(M_IN, u)) !== u) begin
            errors++;
            $display("FAIL inv_in col%0d got %h want %h",
                     k, bm(M_IN, bm(MINV_IN, u)), u);
         end
      end
   endtask

   task automatic test_vectors();
      idle_all();
      ordy  = '1;
      iv    = 4'b0011;
      din[0] = 32'h0024; nexp[0] = '{32'h0001, 8'h0, 1'b0};
      din[1] = 32'h00FF; nexp[1] = '{32'h0001, 8'h0, 1'b0};
      cycle();
      din[0] = 32'h2400; nexp[0] = '{32'h0100, 8'h0, 1'b0};
      din[1] = 32'h0000; nexp[1] = '{32'h0000, 8'h0, 1'b0};
      cycle();
      drain();
   endtask

   task automatic test_remask();
      logic [7:0] x0, x1, x2;
      mat_t       mi;
      int         i;
      x0 = 8'h24; x1 = 8'h5A; x2 = 8'hC3;
      idle_all();
      ordy = '1;
      for (int j = 0; j < 2; j++) begin
         i  = (j == 0) ? 2 : 3;
         mi = minv(i);
         din[i]  = {8'h0, x2, x1, x0};
         rnd[i]  = 32'h0000_3CA5;
         iv[i]   = 1'b1;
         nexp[i] = '{{8'h0, bm(mi, x2) ^ 8'h99, bm(mi, x1) ^ 8'h3C,
                      bm(mi, x0) ^ 8'hA5}, 8'h0, 1'b0};
      end
      cycle();
      for (int j = 0; j < 2; j++) begin
         i = (j == 0) ? 2 : 3;
         nexp[i] = '{32'h0, bm(minv(i), x0 ^ x1 ^ x2), 1'b1};
      end
      cycle();
      drain();
   endtask

   task automatic test_roundtrip();
      logic [7:0]  f, m, b;
      logic [31:0] d;
      int          n;
      idle_all();
      ordy = '1;
      for (int x = 0; x < 256; x++) begin
         for (int i = 0; i < 4; i++) begin
            n = nsh(i);
            f = bm(fwd(i), 8'(x));
            m = '0;
            d = '0;
            for (int s = 0; s < n - 1; s++) begin
               b           = 8'($urandom);
               d[8*s +: 8] = b;
               m           = m ^ b;
            end
            d[8*(n-1) +: 8] = f ^ m;
            din[i]  = d;
            rnd[i]  = $urandom;
            iv[i]   = 1'b1;
            nexp[i] = '{32'h0, 8'(x), 1'b1};
         end
         cycle();
      end
      drain();
   endtask

   task automatic test_latency();
      int i;
      int n;
      for (int j = 0; j < 2; j++) begin
         i = (j == 0) ? 0 : 3;
         idle_all();
         ordy    = '1;
         din[i]  = $urandom;
         rnd[i]  = $urandom;
         nexp[i] = '{model(i, din[i], rnd[i]), 8'h0, 1'b0};
         iv[i]   = 1'b1;
         cycle();
         iv[i] = 1'b0;
         n = 1;
         while (ov[i] !== 1'b1 && n < 10) begin
            cycle();
            n++;
         end
         checks++;
         if (n != pipe(i)) begin
            errors++;
            $display("FAIL latency dut%0d got %0d want %0d", i, n, pipe(i));
         end
         drain();
      end
   endtask

   task automatic test_back_to_back();
      int sent [4];
      int cyc;
      int i;
      idle_all();
      sent = '{default: 0};
      cyc  = 0;
      for (int k = 0; k < 4; k++) acc[k] = 1'b0;
      while ((sent[0] < 10 || iv[0] || sent[3] < 10 || iv[3]) && cyc < 300) begin
         for (int j = 0; j < 2; j++) begin
            i = (j == 0) ? 0 : 3;
            if (!iv[i] || acc[i]) begin
               if (sent[i] < 10) begin
                  din[i]  = $urandom;
                  rnd[i]  = $urandom;
                  nexp[i] = '{model(i, din[i], rnd[i]), 8'h0, 1'b0};
                  iv[i]   = 1'b1;
                  sent[i]++;
               end else begin
                  iv[i] = 1'b0;
               end
            end
            ordy[i] = 1'($urandom_range(0, 1));
         end
         cycle();
         cyc++;
      end
      checks++;
      if (cyc >= 300) begin
         errors++;
         $display("FAIL bp_timeout got %0d cycles want <300", cyc);
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      idle_all();
      ordy = '0;
      for (int k = 0; k < 2; k++) begin
         din[0]  = $urandom;
         nexp[0] = '{model(0, din[0], 32'h0), 8'h0, 1'b0};
         iv[0]   = 1'b1;
         cycle();
      end
      checks++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
         errors++;
         $display("FAIL full got v%b r%b want v1 r0", ov[0], ir[0]);
      end
      rst    = 1'b1;
      din[0] = 32'h0000_5A5A;
      iv[0]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_all();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         hold_pend[i] = 1'b0;
      end
      check_idle(0, "midrst");
      ordy = '1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL stale cyc%0d got v%b d%h want v0", k, ov[0], dout[0]);
         end
         cycle();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_matrix();
      test_vectors();
      test_remask();
      test_latency();
      test_roundtrip();
      test_back_to_back();
      test_reset_midflight();
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
